// File: rtl/t_inject_sched.sv
// Per-client injection scheduler: client FIFO plus a 2-entry re-injection buffer, merged onto one
// switch input slot. A starvation counter forces the FIFO head through under sustained deflection.
// States: NORMAL = RB head has priority | STARVE = FIFO head has priority until it is popped
module t_inject_sched #(
    parameter int N          = 8,
    parameter int A_W        = $clog2(N) + 1,
    parameter int D_W        = 32,
    parameter int CLIENT     = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic           src_v,
    output logic           src_rdy,
    input  logic [A_W-1:0] src_addr,
    input  logic [D_W-1:0] src_data,
    input  logic           inject_ok,
    output logic           net_o_v,
    output logic           net_o_defl,
    output logic [A_W-1:0] net_o_addr,
    output logic [D_W-1:0] net_o_data,
    input  logic           net_i_v,
    input  logic [A_W-1:0] net_i_addr,
    input  logic [D_W-1:0] net_i_data,
    output logic           dst_v,
    output logic [D_W-1:0] dst_data,
    output logic           err_ovf
);
    localparam int FP_W = $clog2(FIFO_DEPTH);
    localparam int WC_W = ($clog2(STARVE_MAX) + 1 > 4) ? $clog2(STARVE_MAX) + 1 : 4;
    localparam int E_W  = A_W + D_W;

    localparam logic [0:0] S_NORMAL = 1'b0;
    localparam logic [0:0] S_STARVE = 1'b1;

    logic [E_W-1:0]  r_fifo_mem [FIFO_DEPTH];
    logic [FP_W:0]   r_fifo_wp;
    logic [FP_W:0]   r_fifo_rp;
    logic [E_W-1:0]  r_rb_mem [2];
    logic [1:0]      r_rb_wp;
    logic [1:0]      r_rb_rp;
    logic [0:0]      r_state;
    logic [WC_W-1:0] r_wcnt;
    logic            r_err_ovf;
    logic            r_net_o_v;
    logic            r_net_o_defl;
    logic [A_W-1:0]  r_net_o_addr;
    logic [D_W-1:0]  r_net_o_data;
    logic            r_dst_v;
    logic [D_W-1:0]  r_dst_data;

    logic [FP_W:0]   w_fifo_cnt;
    logic            w_fifo_empty;
    logic            w_src_rdy;
    logic [1:0]      w_rb_cnt;
    logic            w_rb_empty;
    logic            w_rb_full;
    logic            w_go;
    logic            w_sel_rb;
    logic            w_sel_fifo;
    logic            w_fifo_push;
    logic            w_arr_hit;
    logic            w_arr_miss;
    logic            w_rb_push;
    logic            w_rb_drop;
    logic [E_W-1:0]  w_fifo_head;
    logic [E_W-1:0]  w_rb_head;
    logic [E_W-1:0]  w_sel_entry;

    assign w_fifo_cnt   = r_fifo_wp - r_fifo_rp;
    assign w_fifo_empty = (r_fifo_wp == r_fifo_rp);
    assign w_src_rdy    = (w_fifo_cnt != (FP_W + 1)'(FIFO_DEPTH));
    assign w_rb_cnt     = r_rb_wp - r_rb_rp;
    assign w_rb_empty   = (w_rb_cnt == 2'd0);
    assign w_rb_full    = (w_rb_cnt == 2'd2);

    assign w_go        = ce & inject_ok;
    assign w_sel_rb    = w_go & ~w_rb_empty & ((r_state == S_NORMAL) | w_fifo_empty);
    assign w_sel_fifo  = w_go & ~w_fifo_empty & ~w_sel_rb;
    assign w_fifo_push = ce & src_v & w_src_rdy;
    assign w_arr_hit   = ce & net_i_v & (net_i_addr == A_W'(CLIENT));
    assign w_arr_miss  = ce & net_i_v & (net_i_addr != A_W'(CLIENT));
    // A same-cycle RB pop frees a slot before the arriving packet is written
    assign w_rb_push   = w_arr_miss & (~w_rb_full | w_sel_rb);
    assign w_rb_drop   = w_arr_miss & w_rb_full & ~w_sel_rb;

    assign w_fifo_head = r_fifo_mem[r_fifo_rp[FP_W-1:0]];
    assign w_rb_head   = r_rb_mem[r_rb_rp[0]];
    assign w_sel_entry = w_sel_rb ? w_rb_head : w_fifo_head;

    always_ff @(posedge clk) begin
        if (w_fifo_push) r_fifo_mem[r_fifo_wp[FP_W-1:0]] <= {src_addr, src_data};
        if (w_rb_push)   r_rb_mem[r_rb_wp[0]]            <= {net_i_addr, net_i_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo_wp <= '0;
            r_fifo_rp <= '0;
            r_rb_wp   <= '0;
            r_rb_rp   <= '0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_fifo_push) r_fifo_wp <= r_fifo_wp + 1'b1;
            if (w_sel_fifo)  r_fifo_rp <= r_fifo_rp + 1'b1;
            if (w_rb_push)   r_rb_wp   <= r_rb_wp + 1'b1;
            if (w_sel_rb)    r_rb_rp   <= r_rb_rp + 1'b1;
            if (w_rb_drop)   r_err_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_NORMAL;
            r_wcnt  <= '0;
        end else if (ce) begin
            if (w_sel_fifo) begin
                r_state <= S_NORMAL;
                r_wcnt  <= '0;
            end else if (w_fifo_empty) begin
                r_wcnt <= '0;
            end else if (r_state == S_NORMAL) begin
                if (r_wcnt == WC_W'(STARVE_MAX - 1)) begin
                    r_state <= S_STARVE;
                    r_wcnt  <= '0;
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_net_o_v    <= 1'b0;
            r_net_o_defl <= 1'b0;
            r_net_o_addr <= '0;
            r_net_o_data <= '0;
            r_dst_v      <= 1'b0;
            r_dst_data   <= '0;
        end else begin
            r_net_o_v <= w_sel_rb | w_sel_fifo;
            if (w_sel_rb | w_sel_fifo) begin
                r_net_o_defl <= w_sel_rb;
                {r_net_o_addr, r_net_o_data} <= w_sel_entry;
            end
            r_dst_v <= w_arr_hit;
            if (w_arr_hit) r_dst_data <= net_i_data;
        end
    end

    assign src_rdy    = w_src_rdy;
    assign net_o_v    = r_net_o_v;
    assign net_o_defl = r_net_o_defl;
    assign net_o_addr = r_net_o_addr;
    assign net_o_data = r_net_o_data;
    assign dst_v      = r_dst_v;
    assign dst_data   = r_dst_data;
    assign err_ovf    = r_err_ovf;
endmodule

// File: doc/t_inject_sched.md
# t_inject_sched

Per-client injection scheduler for the deflection-routed BFT. It sits between one client and its leaf port on a level-0 T-switch. New client packets wait in a local FIFO and are injected only in cycles where the switch reports a free input slot. Packets arriving at this client are either delivered (address match) or, if misdelivered by deflection, buffered and re-injected with priority, with a starvation counter guaranteeing forward progress for new traffic.

## Interface
- N, 8, number of clients
- A_W, $clog2(N)+1, packet address width
- D_W, 32, payload width
- CLIENT, 0, this client's address (0..N-1)
- FIFO_DEPTH, 4, client FIFO entries, power of 2, >= 2
- STARVE_MAX, 8, consecutive blocked cycles before FIFO head gets priority, >= 1

- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- ce  in  1  clock enable; all state frozen when 0
- src_v  in  1  client packet valid
- src_rdy  out  1  FIFO not full (combinational from FIFO count)
- src_addr  in  A_W  destination address
- src_data  in  D_W  payload
- inject_ok  in  1  switch input slot free this cycle
- net_o_v  out  1  injected packet valid (registered)
- net_o_defl  out  1  injected packet is a re-injection (registered)
- net_o_addr  out  A_W  injected address (registered)
- net_o_data  out  D_W  injected payload (registered)
- net_i_v  in  1  packet arriving from switch
- net_i_addr  in  A_W  arriving address
- net_i_data  in  D_W  arriving payload
- dst_v  out  1  delivered packet valid (registered, no backpressure)
- dst_data  out  D_W  delivered payload (registered)
- err_ovf  out  1  sticky: re-injection buffer overflowed

## Operation
- Client FIFO: write when ce & src_v & src_rdy. src_rdy = count != FIFO_DEPTH. Pointers are $clog2(FIFO_DEPTH) bits wide plus a wrap bit, so full/empty are unambiguous at wrap-around.
- Arrival, on ce & net_i_v:
  - net_i_addr == CLIENT: dst_v=1 and dst_data=net_i_data on the next edge.
  - Otherwise: push {addr,data} into a 2-entry re-injection buffer (RB).
  - RB full, with no RB pop in the same cycle: drop the arriving packet and set err_ovf. err_ovf is cleared only by rst.
  - A same-cycle RB pop frees the slot first, so the push succeeds.
- Source selection, evaluated on each ce cycle with inject_ok=1:
  - Mode NORMAL: RB head if RB non-empty, else FIFO head if FIFO non-empty, else nothing.
  - Mode STARVE: FIFO head if FIFO non-empty, else RB head.
  - The selected entry is popped and loaded into the net_o_* registers with net_o_v=1. net_o_defl=1 iff the source is RB.
- Starvation FSM, states NORMAL and STARVE, with 4-bit-or-wider counter wcnt:
  - In NORMAL, on each ce cycle with FIFO non-empty and no FIFO pop: wcnt++.
  - When wcnt reaches STARVE_MAX-1 and is incremented: go to STARVE, wcnt=0.
  - Any FIFO pop: wcnt=0 and state goes to NORMAL. A FIFO-pop cycle in STARVE returns the FSM to NORMAL.
  - FIFO empty: wcnt=0.
- ce=0: FIFO, RB, FSM, wcnt and err_ovf hold their values. net_o_v and dst_v load 0. Data registers hold.
- Reset, asynchronous: FIFO and RB empty, state NORMAL, wcnt=0, err_ovf=0, net_o_v=0, net_o_defl=0, dst_v=0, data/addr outputs 0, src_rdy=1. Reset mid-operation discards all buffered packets.

## Timing
- Client accept at edge t: the entry is visible to the selector in cycle t+1, so the earliest net_o_v is at edge t+2.
- Misroute arrival at edge t: the earliest re-injection net_o_v is at edge t+2.
- Matched arrival at edge t: dst_v is high for exactly cycle t+1.
- inject_ok sampled in cycle t drives net_o_v at edge t+1. Each output-valid pulse carries one packet. At most one injection per cycle.
- Simultaneous write and pop of the FIFO when full: not allowed, since src_rdy=0. When empty: not bypassed; the write is injected at the earliest in the next cycle.
- Worst-case FIFO head wait with inject_ok always 1: STARVE_MAX cycles.

## Test plan
- Reset, then one src packet (addr 5, data 0xA5) with inject_ok=1 -> src_rdy=1 throughout; net_o_v pulses once 2 cycles after accept, net_o_addr=5, net_o_defl=0.
- Fill FIFO with 4 packets while inject_ok=0 -> src_rdy=0 after the 4th; raise inject_ok -> 4 injections on consecutive cycles in FIFO order, src_rdy returns to 1.
- net_i_v with addr=CLIENT, data 0x11 -> dst_v=1 for one cycle, dst_data=0x11, no injection; addr≠CLIENT -> injection 2 cycles later with net_o_defl=1.
- Three consecutive misroutes with inject_ok=0 -> 3rd dropped, err_ovf=1 and stays 1; raise inject_ok -> only the first two are re-injected.
- FIFO non-empty plus a misroute every cycle, STARVE_MAX=8, inject_ok=1 -> 8 deflected injections, then one FIFO injection (net_o_defl=0), then back to RB priority.
- Assert rst mid-stream with 3 FIFO entries and 1 RB entry -> all outputs 0 immediately; no injections after release until new src traffic.
